// File: rtl/m_csr_trap_unit_pkg.sv
// Shared constants for the machine-mode CSR file and trap sequencer:
// CSR addresses, op encodings, cause codes and mstatus field positions.
package m_csr_trap_unit_pkg;

    localparam logic [1:0]  XLEN_32B   = 2'd1;
    localparam logic [1:0]  XLEN_64B   = 2'd2;
    localparam logic [31:0] M_STACK_HI = 32'h8000_fff0;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    localparam logic [11:0] CSR_MSTATUS       = 12'h300;
    localparam logic [11:0] CSR_MISA          = 12'h301;
    localparam logic [11:0] CSR_MIE           = 12'h304;
    localparam logic [11:0] CSR_MTVEC         = 12'h305;
    localparam logic [11:0] CSR_MSTATUSH      = 12'h310;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
    localparam logic [11:0] CSR_MEPC          = 12'h341;
    localparam logic [11:0] CSR_MCAUSE        = 12'h342;
    localparam logic [11:0] CSR_MTVAL         = 12'h343;
    localparam logic [11:0] CSR_MIP           = 12'h344;
    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;

    localparam logic [3:0] EXC_ILLEGAL_INSTR = 4'd2;
    localparam logic [3:0] IRQ_MSI           = 4'd3;
    localparam logic [3:0] IRQ_MTI           = 4'd7;
    localparam logic [3:0] IRQ_MEI           = 4'd11;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_UXL_LO = 32;

    // active is {MEI, MTI, MSI}; external beats software beats timer
    function automatic logic [3:0] irq_cause_of(input logic [2:0] active);
        if (active[2])      return IRQ_MEI;
        else if (active[0]) return IRQ_MSI;
        else                return IRQ_MTI;
    endfunction

    function automatic logic [11:0] irq_to_mip(input logic [2:0] bits);
        return {bits[2], 3'b000, bits[1], 3'b000, bits[0], 3'b000};
    endfunction

endpackage

// File: rtl/m_csr_counter64.sv
// 64-bit event counter with inhibit; a write in the same cycle replaces the
// increment. The hi write port loads i_wdata[31:0] into the upper half.
module m_csr_counter64 (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    input  logic        i_inc,
    input  logic        i_inhibit,
    input  logic        i_wr_lo,
    input  logic        i_wr_hi,
    input  logic        i_wr_full,
    input  logic [63:0] i_wdata,
    output logic [63:0] o_count
);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_count <= '0;
        end else if (i_en) begin
            if (i_wr_full) begin
                o_count <= i_wdata;
            end else if (i_wr_lo || i_wr_hi) begin
                if (i_wr_lo) o_count[31:0]  <= i_wdata[31:0];
                if (i_wr_hi) o_count[63:32] <= i_wdata[31:0];
            end else if (i_inc && !i_inhibit) begin
                o_count <= o_count + 64'd1;
            end
        end
    end

endmodule

// File: rtl/m_csr_trap_unit.sv
// Machine-mode CSR file with internal read-modify-write, interrupt arbitration,
// trap entry / mret sequencing and the fetch redirect they produce.
module m_csr_trap_unit
    import m_csr_trap_unit_pkg::*;
#(
    parameter logic [1:0]  XLEN           = XLEN_64B,
    parameter logic [31:0] MSCRATCH_RESET = M_STACK_HI & 32'hffff_fffc,
    parameter logic [63:0] MTVEC_RESET    = 64'h0,
    localparam int         W              = 1 << (int'(XLEN) + 4)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clk_en,
    input  logic [11:0]  i_csr_addr,
    input  logic [1:0]   i_csr_op,
    input  logic [W-1:0] i_csr_wdata,
    output logic [W-1:0] o_csr_rdata,
    output logic         o_csr_illegal,
    input  logic         i_exc_valid,
    input  logic [3:0]   i_exc_code,
    input  logic [W-1:0] i_exc_pc,
    input  logic [W-1:0] i_exc_tval,
    input  logic [2:0]   i_irq_pending,
    input  logic [W-1:0] i_irq_pc,
    input  logic         i_mret,
    input  logic         i_instr_retired,
    output logic         o_trap_redirect,
    output logic [W-1:0] o_trap_pc,
    output logic         o_irq_take,
    output logic [W-1:0] o_mepc,
    output logic [W-1:0] o_mstatus,
    output logic [W-1:0] o_mtvec,
    output logic [1:0]   o_UXL
);

    localparam bit           IS_32         = (W == 32);
    localparam logic [W-1:0] MSCRATCH_INIT = W'($signed(MSCRATCH_RESET));
    localparam logic [W-1:0] MTVEC_INIT    = {MTVEC_RESET[W-1:2], 2'b00};

    logic         st_mie, st_mpie;
    logic [1:0]   st_mpp;
    logic [2:0]   mie_q;
    logic [2:0]   mcountinhibit_q;
    logic [W-1:0] mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
    logic [63:0]  mcycle, minstret;

    logic [W-1:0] xl_field, mstatus_w, misa_w, rd_val, wval, base, trap_pc;
    logic         addr_ok, addr_ro, csr_we, irq_take;
    logic [2:0]   irq_active;
    logic [3:0]   irq_cause_w;
    logic [63:0]  ctr_wdata;

    // UXL/SXL only exist in the 64-bit mstatus layout
    if (IS_32) begin : g_xl32
        assign xl_field = '0;
    end else begin : g_xl64
        assign xl_field = W'({XLEN, XLEN}) << MSTATUS_UXL_LO;
    end

    assign mstatus_w = xl_field
                     | (W'(st_mpp)  << MSTATUS_MPP_LO)
                     | (W'(st_mpie) << MSTATUS_MPIE)
                     | (W'(st_mie)  << MSTATUS_MIE);
    assign misa_w    = (W'(XLEN) << (W - 2)) | W'(26'h100);

    assign irq_active  = i_irq_pending & mie_q;
    assign irq_cause_w = irq_cause_of(irq_active);
    assign irq_take    = st_mie && (|irq_active) && !i_exc_valid;
    assign base        = {mtvec_q[W-1:2], 2'b00};

    always_comb begin
        if (i_exc_valid)   trap_pc = base;
        else if (irq_take) trap_pc = mtvec_q[0] ? base + (W'(irq_cause_w) << 2) : base;
        else               trap_pc = mepc_q;
    end

    always_comb begin
        rd_val  = '0;
        addr_ok = 1'b1;
        addr_ro = 1'b0;
        case (i_csr_addr)
            CSR_MSTATUS:       rd_val = mstatus_w;
            CSR_MISA:          begin rd_val = misa_w; addr_ro = 1'b1; end
            CSR_MIE:           rd_val = W'(irq_to_mip(mie_q));
            CSR_MTVEC:         rd_val = mtvec_q;
            CSR_MSTATUSH:      begin addr_ok = IS_32; addr_ro = 1'b1; end
            CSR_MCOUNTINHIBIT: rd_val = W'(mcountinhibit_q);
            CSR_MSCRATCH:      rd_val = mscratch_q;
            CSR_MEPC:          rd_val = mepc_q;
            CSR_MCAUSE:        rd_val = mcause_q;
            CSR_MTVAL:         rd_val = mtval_q;
            CSR_MIP:           begin rd_val = W'(irq_to_mip(i_irq_pending)); addr_ro = 1'b1; end
            CSR_MCYCLE:        rd_val = W'(mcycle);
            CSR_MINSTRET:      rd_val = W'(minstret);
            CSR_MCYCLEH:       begin addr_ok = IS_32; if (IS_32) rd_val = W'(mcycle >> 32); end
            CSR_MINSTRETH:     begin addr_ok = IS_32; if (IS_32) rd_val = W'(minstret >> 32); end
            default:           addr_ok = 1'b0;
        endcase
    end

    always_comb begin
        case (i_csr_op)
            CSR_OP_RW: wval = i_csr_wdata;
            CSR_OP_RS: wval = rd_val | i_csr_wdata;
            CSR_OP_RC: wval = rd_val & ~i_csr_wdata;
            default:   wval = rd_val;
        endcase
    end

    // Traps and mret pre-empt the CSR write; the pipeline replays it
    assign csr_we = i_clk_en && (i_csr_op != CSR_OP_NONE) && addr_ok && !addr_ro
                 && !i_exc_valid && !irq_take && !i_mret;
    assign ctr_wdata = 64'(wval);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            st_mie          <= 1'b0;
            st_mpie         <= 1'b1;
            st_mpp          <= 2'b00;
            mie_q           <= '0;
            mcountinhibit_q <= '0;
            mtvec_q         <= MTVEC_INIT;
            mscratch_q      <= MSCRATCH_INIT;
            mepc_q          <= '0;
            mcause_q        <= '0;
            mtval_q         <= '0;
        end else if (i_clk_en) begin
            if (i_exc_valid || irq_take) begin
                mepc_q   <= (i_exc_valid ? i_exc_pc : i_irq_pc) & ~W'(3);
                mcause_q <= i_exc_valid ? W'(i_exc_code) : {1'b1, {(W-5){1'b0}}, irq_cause_w};
                mtval_q  <= i_exc_valid ? i_exc_tval : '0;
                st_mpie  <= st_mie;
                st_mie   <= 1'b0;
                st_mpp   <= 2'b11;
            end else if (i_mret) begin
                st_mie  <= st_mpie;
                st_mpie <= 1'b1;
                st_mpp  <= 2'b00;
            end else if (csr_we) begin
                case (i_csr_addr)
                    CSR_MSTATUS: begin
                        st_mie  <= wval[MSTATUS_MIE];
                        st_mpie <= wval[MSTATUS_MPIE];
                        st_mpp  <= {2{&wval[MSTATUS_MPP_LO +: 2]}};
                    end
                    CSR_MIE:           mie_q <= {wval[11], wval[7], wval[3]};
                    CSR_MTVEC:         mtvec_q <= {wval[W-1:2], wval[1] ? mtvec_q[1:0] : wval[1:0]};
                    CSR_MCOUNTINHIBIT: mcountinhibit_q <= {wval[2], 1'b0, wval[0]};
                    CSR_MSCRATCH:      mscratch_q <= wval;
                    CSR_MEPC:          mepc_q <= wval & ~W'(3);
                    CSR_MCAUSE:        mcause_q <= wval;
                    CSR_MTVAL:         mtval_q <= wval;
                    default:           ;
                endcase
            end
        end
    end

    m_csr_counter64 u_mcycle (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_en      (i_clk_en),
        .i_inc     (1'b1),
        .i_inhibit (mcountinhibit_q[0]),
        .i_wr_lo   (csr_we && i_csr_addr == CSR_MCYCLE && IS_32),
        .i_wr_hi   (csr_we && i_csr_addr == CSR_MCYCLEH),
        .i_wr_full (csr_we && i_csr_addr == CSR_MCYCLE && !IS_32),
        .i_wdata   (ctr_wdata),
        .o_count   (mcycle)
    );

    m_csr_counter64 u_minstret (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_en      (i_clk_en),
        .i_inc     (i_instr_retired),
        .i_inhibit (mcountinhibit_q[2]),
        .i_wr_lo   (csr_we && i_csr_addr == CSR_MINSTRET && IS_32),
        .i_wr_hi   (csr_we && i_csr_addr == CSR_MINSTRETH),
        .i_wr_full (csr_we && i_csr_addr == CSR_MINSTRET && !IS_32),
        .i_wdata   (ctr_wdata),
        .o_count   (minstret)
    );

    assign o_csr_rdata     = rd_val;
    assign o_csr_illegal   = (i_csr_op != CSR_OP_NONE) && !addr_ok;
    assign o_trap_redirect = i_exc_valid || irq_take || i_mret;
    assign o_trap_pc       = trap_pc;
    assign o_irq_take      = irq_take;
    assign o_mepc          = mepc_q;
    assign o_mstatus       = mstatus_w;
    assign o_mtvec         = mtvec_q;
    assign o_UXL           = XLEN;

endmodule
